// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and data-bits configuration codes.
// Used by both the receive deserializer and the transmitter.
package uart_pkg;

    // Receiver framing states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // Encoding of the 2-bit data-bits configuration field.
    localparam logic [1:0] DATA_BITS_5 = 2'b00;
    localparam logic [1:0] DATA_BITS_6 = 2'b01;
    localparam logic [1:0] DATA_BITS_7 = 2'b10;
    localparam logic [1:0] DATA_BITS_8 = 2'b11;

    // Index of the last data bit in a character: 5 data bits -> 4, 8 data bits -> 7.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits_code);
        return 3'd4 + {1'b0, data_bits_code};
    endfunction

endpackage : uart_pkg

// File: rtl/uart_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// The reset value is a parameter so a serial line can come out of reset at its idle level.
module uart_sync_ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the chain resets to the line's idle level, not to 0; a 0 here would
            // look like a start bit the moment reset is released.
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            // NOTE: non-blocking assignment, so each stage captures the previous stage's
            // value from before this edge and the chain really is SYNC_STAGES deep.
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule : uart_sync_ff

// File: rtl/uart_rx_deserializer.sv
// Serial-to-parallel receive stage of the APB UART.
// Oversamples the synchronized rx line, frames start/data/parity/stop bits and pushes
// one character with its error flags per frame into the receiver FIFO.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_tick_i,
    input  logic       rx_i,
    input  logic       rx_en_i,
    input  logic [1:0] cfg_data_bits_i,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_parity_even_i,
    input  logic       fifo_full_i,
    output logic [7:0] rx_data_o,
    output logic       rx_push_o,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_break_o,
    output logic       rx_overrun_o,
    output logic       rx_busy_o
);

    localparam int                CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]  SAMPLE_PT = CNT_W'(OVERSAMPLE / 2 - 1);

    rx_state_t        state_q;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;

    // Frame configuration captured when the start bit is validated.
    logic [2:0]       last_idx_q;
    logic             par_en_q;
    logic             par_even_q;

    // Parity result and raw parity bit of the frame in progress.
    logic             perr_pend_q;
    logic             par_bit_q;

    logic             sample_pt;
    logic             stop_ferr;
    logic             stop_brk;

    uart_sync_ff #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_i),
        .q       (rx_s)
    );

    assign sample_pt = baud_tick_i && (cnt_q == SAMPLE_PT);

    // A low stop bit is a framing error; it is a break when every other bit was low too.
    assign stop_ferr = ~rx_s;
    assign stop_brk  = stop_ferr && (shift_q == 8'h00) && (!par_en_q || !par_bit_q);

    assign rx_busy_o = (state_q != IDLE);

    // Receive FSM, bit-position counter, data shifter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            last_idx_q      <= '0;
            par_en_q        <= 1'b0;
            par_even_q      <= 1'b0;
            perr_pend_q     <= 1'b0;
            par_bit_q       <= 1'b0;
            rx_data_o       <= '0;
            rx_push_o       <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_break_o      <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            // NOTE: the strobes default low here so a single assignment further down
            // produces exactly a one-cycle pulse.
            rx_push_o    <= 1'b0;
            rx_overrun_o <= 1'b0;

            if (state_q inside {START, DATA, PARITY, STOP} && baud_tick_i) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (!rx_en_i) begin
                // Receiver disabled: abandon any frame, keep the last reported flags.
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= START;
                        end
                    end

                    START: begin
                        if (sample_pt) begin
                            if (rx_s) begin
                                state_q <= IDLE;
                            end else begin
                                state_q     <= DATA;
                                bit_idx_q   <= '0;
                                shift_q     <= '0;
                                last_idx_q  <= last_bit_idx(cfg_data_bits_i);
                                par_en_q    <= cfg_parity_en_i;
                                par_even_q  <= cfg_parity_even_i;
                                perr_pend_q <= 1'b0;
                                par_bit_q   <= 1'b0;
                            end
                        end
                    end

                    DATA: begin
                        if (sample_pt) begin
                            shift_q[bit_idx_q] <= rx_s;
                            if (bit_idx_q == last_idx_q) begin
                                state_q <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                    end

                    PARITY: begin
                        if (sample_pt) begin
                            perr_pend_q <= ^shift_q ^ rx_s ^ ~par_even_q;
                            par_bit_q   <= rx_s;
                            state_q     <= STOP;
                        end
                    end

                    STOP: begin
                        if (sample_pt) begin
                            rx_data_o       <= shift_q;
                            rx_parity_err_o <= perr_pend_q;
                            rx_frame_err_o  <= stop_ferr;
                            rx_break_o      <= stop_brk;
                            if (fifo_full_i) begin
                                rx_overrun_o <= 1'b1;
                            end else begin
                                rx_push_o <= 1'b1;
                            end
                            state_q <= stop_brk ? BRK_WAIT : IDLE;
                        end
                    end

                    BRK_WAIT: begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : uart_rx_deserializer

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus randomized
// frames, compared against a frame-level reference model.
module tb_uart_rx_deserializer;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } char_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       baud_tick;
    logic       rx_i;
    logic       rx_en;
    logic [1:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_parity_even;
    logic       fifo_full;
    logic [7:0] rx_data;
    logic       rx_push;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_break;
    logic       rx_overrun;
    logic       rx_busy;

    int    n_vec = 0;
    int    n_err = 0;
    int    overrun_cycles = 0;
    char_t push_q[$];
    char_t exp_char;

    uart_rx_deserializer #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (2)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .baud_tick_i       (baud_tick),
        .rx_i              (rx_i),
        .rx_en_i           (rx_en),
        .cfg_data_bits_i   (cfg_data_bits),
        .cfg_parity_en_i   (cfg_parity_en),
        .cfg_parity_even_i (cfg_parity_even),
        .fifo_full_i       (fifo_full),
        .rx_data_o         (rx_data),
        .rx_push_o         (rx_push),
        .rx_parity_err_o   (rx_parity_err),
        .rx_frame_err_o    (rx_frame_err),
        .rx_break_o        (rx_break),
        .rx_overrun_o      (rx_overrun),
        .rx_busy_o         (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud ticks with random spacing of 1 or 2 clocks (back-to-back ticks included).
    initial begin
        int gap_left;
        gap_left  = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (gap_left == 0) begin
                baud_tick = 1'b1;
                gap_left  = $urandom_range(0, 1);
            end else begin
                baud_tick = 1'b0;
                gap_left--;
            end
        end
    end

    // Capture every push and count overrun cycles, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (rx_push === 1'b1) begin
                    push_q.push_back('{rx_data, rx_parity_err, rx_frame_err, rx_break});
                end
                if (rx_overrun === 1'b1) begin
                    overrun_cycles++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (baud_tick) k++;
        end
        #1;
    endtask

    // Parity bit placed on the line: correct for the configured sense unless flipped.
    function automatic bit line_parity(input logic [7:0] d, input logic [1:0] code,
                                       input bit even, input bit flip);
        int n;
        int ones;
        n    = 5 + int'(code);
        ones = $countones(d & 8'((1 << n) - 1));
        return bit'((even ? (ones % 2) : (1 - ones % 2)) ^ int'(flip));
    endfunction

    // What the receiver must report for a frame carrying these fields.
    function automatic char_t model(input logic [7:0] d, input logic [1:0] code, input bit pen,
                                    input bit even, input bit flip, input bit stop);
        char_t c;
        int    n;
        int    ones;
        bit    pbit;
        n      = 5 + int'(code);
        c.data = d & 8'((1 << n) - 1);
        ones   = $countones(c.data);
        pbit   = line_parity(d, code, even, flip);
        c.perr = pen && (((ones + int'(pbit)) % 2) != (even ? 0 : 1));
        c.ferr = !stop;
        c.brk  = !stop && (c.data == 8'h00) && (!pen || !pbit);
        return c;
    endfunction

    task automatic send_bit(input logic b, input int ticks);
        rx_i = b;
        wait_ticks(ticks);
    endtask

    // Drive one frame, optionally scrambling the config once the start bit is accepted.
    // A low stop bit is cut short so the line is high before any restart is sampled.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] code, input bit pen,
                              input bit even, input bit flip, input bit stop, input bit scramble);
        int n;
        n               = 5 + int'(code);
        cfg_data_bits   = code;
        cfg_parity_en   = pen;
        cfg_parity_even = even;
        send_bit(1'b0, OS);
        check("busy_mid_frame", rx_busy, 1'b1);
        if (scramble) begin
            cfg_data_bits   = 2'($urandom_range(0, 3));
            cfg_parity_en   = 1'($urandom_range(0, 1));
            cfg_parity_even = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < n; i++) send_bit(d[i], OS);
        if (pen) send_bit(line_parity(d, code, even, flip), OS);
        send_bit(stop, stop ? OS : 12);
        send_bit(1'b1, OS);
        exp_char = model(d, code, pen, even, flip, stop);
    endtask

    task automatic expect_char(input string tag);
        char_t got;
        check({tag, "_push_count"}, push_q.size(), 1);
        if (push_q.size() > 0) begin
            got = push_q.pop_front();
            check(tag, 32'(got), 32'(exp_char));
        end
        check({tag, "_busy_after"}, rx_busy, 1'b0);
        push_q.delete();
    endtask

    initial begin
        int oc0;
        char_t last;

        reset_n         = 1'b0;
        rx_i            = 1'b1;
        rx_en           = 1'b1;
        cfg_data_bits   = 2'b11;
        cfg_parity_en   = 1'b0;
        cfg_parity_even = 1'b0;
        fifo_full       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {rx_data, rx_push, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy}, 14'h0);
        reset_n = 1'b1;
        wait_ticks(20);
        check("idle_ticks_busy", rx_busy, 1'b0);

        // 8N1 0xA5
        send_frame(8'hA5, 2'b11, 0, 0, 0, 1, 0);
        expect_char("8n1_a5");

        // 7E1 0x35, correct then flipped parity
        send_frame(8'h35, 2'b10, 1, 1, 0, 1, 0);
        expect_char("7e1_good");
        send_frame(8'h35, 2'b10, 1, 1, 1, 1, 0);
        expect_char("7e1_flipped");

        // 5N1 0x1F with a low stop bit
        send_frame(8'h1F, 2'b00, 0, 0, 0, 0, 0);
        expect_char("5n1_frame_err");

        // Line held low for two 8N1 frame times: one break char, then silence
        cfg_data_bits = 2'b11;
        cfg_parity_en = 1'b0;
        rx_i          = 1'b0;
        wait_ticks(20 * OS);
        exp_char = model(8'h00, 2'b11, 0, 0, 0, 0);
        check("break_push_count", push_q.size(), 1);
        if (push_q.size() > 0) check("break_char", 32'(push_q.pop_front()), 32'(exp_char));
        check("break_wait_busy", rx_busy, 1'b1);
        rx_i = 1'b1;
        wait_ticks(2 * OS);
        check("break_release_busy", rx_busy, 1'b0);
        check("break_no_extra_push", push_q.size(), 0);
        send_frame(8'h3C, 2'b11, 0, 0, 0, 1, 0);
        expect_char("after_break_3c");

        // Short low glitch on an idle line
        rx_i = 1'b0;
        wait_ticks(4);
        rx_i = 1'b1;
        wait_ticks(2 * OS);
        check("glitch_busy", rx_busy, 1'b0);
        check("glitch_no_push", push_q.size(), 0);

        // Overrun on a full FIFO, then a normal char
        oc0       = overrun_cycles;
        fifo_full = 1'b1;
        send_frame(8'h55, 2'b11, 0, 0, 0, 1, 0);
        fifo_full = 1'b0;
        check("overrun_no_push", push_q.size(), 0);
        check("overrun_pulse_cycles", overrun_cycles - oc0, 1);
        send_frame(8'hC3, 2'b11, 1, 0, 0, 1, 0);
        expect_char("after_overrun");
        last = exp_char;

        // Receiver disabled mid-frame: abort, no push, flags held
        send_bit(1'b0, OS);
        send_bit(1'b1, OS);
        rx_en = 1'b0;
        wait_ticks(2);
        check("disable_busy", rx_busy, 1'b0);
        send_bit(1'b0, 3 * OS);
        rx_i = 1'b1;
        wait_ticks(OS);
        rx_en = 1'b1;
        wait_ticks(2 * OS);
        check("disable_no_push", push_q.size(), 0);
        check("disable_flags_held", {rx_data, rx_parity_err, rx_frame_err, rx_break}, 32'(last));

        // Asynchronous reset in the middle of the data bits
        cfg_data_bits = 2'b11;
        cfg_parity_en = 1'b0;
        send_bit(1'b0, OS);
        send_bit(1'b1, OS);
        send_bit(1'b0, OS);
        send_bit(1'b0, OS / 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {rx_data, rx_push, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy}, 14'h0);
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        push_q.delete();
        wait_ticks(4);
        send_frame(8'h81, 2'b11, 0, 0, 0, 1, 0);
        expect_char("after_reset_81");

        // Randomized frames with config scrambled after start-bit acceptance
        for (int i = 0; i < 14; i++) begin
            send_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 1'b1);
            expect_char($sformatf("random_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_rx_deserializer
